// File: rtl/weight_pingpong_ctrl.sv
// Ping-pong weight memory sequencer: a loader fills one bank while compute reads the other.
// Bank ownership is tracked per bank; the write/read bank is chosen by the address MSB.
module weight_pingpong_ctrl #(
  parameter  int WEIGHT_MEMORY_ADDR_SIZE = 16,
  localparam int CNT_W = WEIGHT_MEMORY_ADDR_SIZE - 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ld_start,
  input  logic [CNT_W-1:0]                   ld_len,
  input  logic                               ld_fc,
  input  logic                               ld_valid,
  output logic                               ld_ready,
  output logic                               wr_en_ext_fc_w,
  output logic                               wr_en_ext_cnn_w,
  output logic [WEIGHT_MEMORY_ADDR_SIZE-1:0] wr_addr_ext_w,
  input  logic                               cmp_req,
  output logic                               cmp_grant,
  input  logic                               cmp_done,
  output logic [WEIGHT_MEMORY_ADDR_SIZE-1:0] weight_memory_pointer,
  output logic [3:0]                         bank_state,
  output logic                               ld_err
);

  typedef enum logic [1:0] {B_EMPTY = 2'd0, B_LOADING = 2'd1, B_FULL = 2'd2, B_IN_USE = 2'd3} bank_e;
  typedef enum logic [1:0] {L_IDLE, L_WAIT, L_LOAD} lst_e;
  typedef enum logic {C_IDLE, C_ACTIVE} cst_e;

  bank_e [1:0]                  bank_q, bank_d;
  lst_e                         lst_q, lst_d;
  cst_e                         cst_q, cst_d;
  logic                         wb_q, wb_d, rb_q, rb_d, fc_q, fc_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d, len_q, len_d;
  logic                         grant_q, grant_d, err_q, err_d;
  logic [WEIGHT_MEMORY_ADDR_SIZE-1:0] ptr_q, ptr_d;

  always_comb begin
    bank_d  = bank_q;
    lst_d   = lst_q;
    cst_d   = cst_q;
    wb_d    = wb_q;
    rb_d    = rb_q;
    fc_d    = fc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    grant_d = 1'b0;
    err_d   = ld_start && ((lst_q != L_IDLE) || (ld_len == '0));

    // Compute and loader never touch the same bank in one cycle: their
    // source states (FULL/IN_USE vs EMPTY/LOADING) are disjoint.
    case (cst_q)
      C_IDLE: if (cmp_req && bank_q[rb_q] == B_FULL) begin
        bank_d[rb_q] = B_IN_USE;
        grant_d      = 1'b1;
        ptr_d        = {rb_q, {CNT_W{1'b0}}};
        cst_d        = C_ACTIVE;
      end
      C_ACTIVE: if (cmp_done) begin
        bank_d[rb_q] = B_EMPTY;
        rb_d         = ~rb_q;
        cst_d        = C_IDLE;
      end
      default: cst_d = C_IDLE;
    endcase

    case (lst_q)
      L_IDLE: if (ld_start && ld_len != '0) begin
        len_d = ld_len;
        fc_d  = ld_fc;
        cnt_d = '0;
        if (bank_q[wb_q] == B_EMPTY) begin
          bank_d[wb_q] = B_LOADING;
          lst_d        = L_LOAD;
        end else begin
          lst_d = L_WAIT;
        end
      end
      L_WAIT: if (bank_q[wb_q] == B_EMPTY) begin
        bank_d[wb_q] = B_LOADING;
        lst_d        = L_LOAD;
      end
      L_LOAD: if (ld_valid) begin
        if (cnt_q == len_q - CNT_W'(1)) begin
          bank_d[wb_q] = B_FULL;
          wb_d         = ~wb_q;
          cnt_d        = '0;
          lst_d        = L_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: lst_d = L_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bank_q  <= {B_EMPTY, B_EMPTY};
      lst_q   <= L_IDLE;
      cst_q   <= C_IDLE;
      wb_q    <= 1'b0;
      rb_q    <= 1'b0;
      fc_q    <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      ptr_q   <= '0;
      grant_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      bank_q  <= bank_d;
      lst_q   <= lst_d;
      cst_q   <= cst_d;
      wb_q    <= wb_d;
      rb_q    <= rb_d;
      fc_q    <= fc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

  // Write strobes pass ld_valid straight through so data needs no staging.
  assign ld_ready              = (lst_q == L_LOAD);
  assign wr_en_ext_fc_w        = ld_ready && ld_valid && fc_q;
  assign wr_en_ext_cnn_w       = ld_ready && ld_valid && !fc_q;
  assign wr_addr_ext_w         = {wb_q, cnt_q};
  assign cmp_grant             = grant_q;
  assign weight_memory_pointer = ptr_q;
  assign bank_state            = bank_q;
  assign ld_err                = err_q;

endmodule

// File: tb/tb_weight_pingpong_ctrl.sv
// Bench for weight_pingpong_ctrl: directed vector table, then random traffic vs. a bank-ownership model.
module tb_weight_pingpong_ctrl;
  localparam int AW = 16;
  localparam int CW = AW - 1;

  logic          clk = 1'b0;
  logic          reset, ld_start, ld_fc, ld_valid, cmp_req, cmp_done;
  logic [CW-1:0] ld_len;
  logic          ld_ready, wr_en_ext_fc_w, wr_en_ext_cnn_w, cmp_grant, ld_err;
  logic [AW-1:0] wr_addr_ext_w, weight_memory_pointer;
  logic [3:0]    bank_state;

  int n_vec = 0;
  int n_bad = 0;

  weight_pingpong_ctrl #(.WEIGHT_MEMORY_ADDR_SIZE(AW)) dut (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_len(ld_len), .ld_fc(ld_fc),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .wr_en_ext_fc_w(wr_en_ext_fc_w),
    .wr_en_ext_cnn_w(wr_en_ext_cnn_w), .wr_addr_ext_w(wr_addr_ext_w), .cmp_req(cmp_req),
    .cmp_grant(cmp_grant), .cmp_done(cmp_done), .weight_memory_pointer(weight_memory_pointer),
    .bank_state(bank_state), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, st; int len; bit fc, vld, req, done;
    bit rdy, wfc, wcnn; int addr; bit gnt; int ptr; int bs; bit err;
  } vec_t;
  vec_t tbl[$];

  // Reference model: bank ownership as plain integers (0 EMPTY,1 LOADING,2 FULL,3 IN_USE).
  int m_bank[2];
  int m_wb, m_rb, m_lmode, m_cnt, m_len, m_fc, m_cact, m_gnt, m_ptr, m_err;

  task automatic model_reset();
    m_bank[0] = 0; m_bank[1] = 0;
    m_wb = 0; m_rb = 0; m_lmode = 0; m_cnt = 0; m_len = 0; m_fc = 0;
    m_cact = 0; m_gnt = 0; m_ptr = 0; m_err = 0;
  endtask

  task automatic model_step(bit rst, bit st, int len, bit fc, bit vld, bit req, bit done);
    int nb[2];
    if (!rst) begin model_reset(); return; end
    nb = m_bank;
    m_err = (st && (m_lmode != 0 || len == 0)) ? 1 : 0;
    m_gnt = 0;
    if (m_cact == 0) begin
      if (req && m_bank[m_rb] == 2) begin
        nb[m_rb] = 3; m_gnt = 1; m_ptr = m_rb * 32768; m_cact = 1;
      end
    end else if (done) begin
      nb[m_rb] = 0; m_rb = 1 - m_rb; m_cact = 0;
    end
    if (m_lmode == 0) begin
      if (st && len != 0) begin
        m_len = len; m_fc = fc; m_cnt = 0;
        if (m_bank[m_wb] == 0) begin m_lmode = 2; nb[m_wb] = 1; end
        else m_lmode = 1;
      end
    end else if (m_lmode == 1) begin
      if (m_bank[m_wb] == 0) begin m_lmode = 2; nb[m_wb] = 1; end
    end else if (vld) begin
      m_cnt++;
      if (m_cnt == m_len) begin nb[m_wb] = 2; m_wb = 1 - m_wb; m_cnt = 0; m_lmode = 0; end
    end
    m_bank = nb;
  endtask

  task automatic drive(bit rst, bit st, int len, bit fc, bit vld, bit req, bit done);
    reset = rst; ld_start = st; ld_len = CW'(len); ld_fc = fc;
    ld_valid = vld; cmp_req = req; cmp_done = done;
  endtask

  task automatic check(string nm, bit rdy, bit wfc, bit wcnn, int addr, bit gnt, int ptr, int bs, bit err);
    logic [40:0] a, e;
    e = {rdy, wfc, wcnn, gnt, err, 4'(bs), 16'(ptr), (wfc | wcnn) ? 16'(addr) : 16'h0};
    a = {ld_ready, wr_en_ext_fc_w, wr_en_ext_cnn_w, cmp_grant, ld_err, bank_state,
         weight_memory_pointer, (wfc | wcnn) ? wr_addr_ext_w : 16'h0};
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got rdy,fc,cnn,gnt,err=%b bs=%h ptr=%h addr=%h; want %b bs=%h ptr=%h addr=%h",
               nm, a[40:36], a[35:32], a[31:16], a[15:0], e[40:36], e[35:32], e[31:16], e[15:0]);
    end
  endtask

  initial begin
    // rst st len fc vld req done | rdy wfc wcnn addr gnt ptr bs err
    tbl.push_back('{1,0,0,0,0,0,0, 0,0,0,'h0000,0,'h0000,'h0,0}); // reset state
    tbl.push_back('{1,1,4,1,0,0,0, 0,0,0,'h0000,0,'h0000,'h0,0}); // load bank0 fc len4
    tbl.push_back('{1,0,0,0,1,0,0, 1,1,0,'h0000,0,'h0000,'h1,0});
    tbl.push_back('{1,0,0,0,1,0,0, 1,1,0,'h0001,0,'h0000,'h1,0});
    tbl.push_back('{1,0,0,0,1,0,0, 1,1,0,'h0002,0,'h0000,'h1,0});
    tbl.push_back('{1,0,0,0,1,0,0, 1,1,0,'h0003,0,'h0000,'h1,0});
    tbl.push_back('{1,0,0,0,0,0,0, 0,0,0,'h0000,0,'h0000,'h2,0});
    tbl.push_back('{1,1,3,0,0,0,0, 0,0,0,'h0000,0,'h0000,'h2,0}); // load bank1 cnn len3
    tbl.push_back('{1,0,0,0,1,0,0, 1,0,1,'h8000,0,'h0000,'h6,0});
    tbl.push_back('{1,0,0,0,0,0,0, 1,0,0,'h0000,0,'h0000,'h6,0});
    tbl.push_back('{1,0,0,0,1,0,0, 1,0,1,'h8001,0,'h0000,'h6,0});
    tbl.push_back('{1,0,0,0,0,0,0, 1,0,0,'h0000,0,'h0000,'h6,0});
    tbl.push_back('{1,0,0,0,1,0,0, 1,0,1,'h8002,0,'h0000,'h6,0});
    tbl.push_back('{1,0,0,0,0,0,0, 0,0,0,'h0000,0,'h0000,'hA,0});
    tbl.push_back('{1,0,0,0,0,1,0, 0,0,0,'h0000,0,'h0000,'hA,0}); // grant bank0
    tbl.push_back('{1,1,2,1,0,0,0, 0,0,0,'h0000,1,'h0000,'hB,0}); // third load -> wait
    tbl.push_back('{1,0,0,0,0,0,0, 0,0,0,'h0000,0,'h0000,'hB,0});
    tbl.push_back('{1,0,0,0,0,0,1, 0,0,0,'h0000,0,'h0000,'hB,0}); // free bank0
    tbl.push_back('{1,0,0,0,0,0,0, 0,0,0,'h0000,0,'h0000,'h8,0}); // bubble
    tbl.push_back('{1,1,5,0,1,0,0, 1,1,0,'h0000,0,'h0000,'h9,0}); // start during load
    tbl.push_back('{1,0,0,0,1,0,0, 1,1,0,'h0001,0,'h0000,'h9,1});
    tbl.push_back('{1,0,0,0,0,0,0, 0,0,0,'h0000,0,'h0000,'hA,0});
    tbl.push_back('{1,0,0,0,0,1,0, 0,0,0,'h0000,0,'h0000,'hA,0}); // grant bank1
    tbl.push_back('{1,0,0,0,0,1,0, 0,0,0,'h0000,1,'h8000,'hE,0});
    tbl.push_back('{1,0,0,0,0,1,0, 0,0,0,'h0000,0,'h8000,'hE,0}); // req ignored while active
    tbl.push_back('{1,0,0,0,0,0,1, 0,0,0,'h0000,0,'h8000,'hE,0});
    tbl.push_back('{1,0,0,0,0,0,0, 0,0,0,'h0000,0,'h8000,'h2,0});
    tbl.push_back('{1,0,0,0,0,1,0, 0,0,0,'h0000,0,'h8000,'h2,0});
    tbl.push_back('{1,0,0,0,0,0,1, 0,0,0,'h0000,1,'h0000,'h3,0});
    tbl.push_back('{1,1,0,0,0,0,0, 0,0,0,'h0000,0,'h0000,'h0,0}); // len 0 rejected
    tbl.push_back('{1,0,0,0,0,0,0, 0,0,0,'h0000,0,'h0000,'h0,1});
    tbl.push_back('{1,0,0,0,0,1,0, 0,0,0,'h0000,0,'h0000,'h0,0}); // req, both empty
    tbl.push_back('{1,1,1,1,0,1,0, 0,0,0,'h0000,0,'h0000,'h0,0});
    tbl.push_back('{1,0,0,0,1,1,0, 1,1,0,'h8000,0,'h0000,'h4,0});
    tbl.push_back('{1,0,0,0,0,1,0, 0,0,0,'h0000,0,'h0000,'h8,0});
    tbl.push_back('{1,0,0,0,0,0,0, 0,0,0,'h0000,1,'h8000,'hC,0});
    tbl.push_back('{1,1,4,0,0,0,0, 0,0,0,'h0000,0,'h8000,'hC,0}); // load while active
    tbl.push_back('{1,0,0,0,1,0,0, 1,0,1,'h0000,0,'h8000,'hD,0});
    tbl.push_back('{1,0,0,0,1,0,0, 1,0,1,'h0001,0,'h8000,'hD,0});
    tbl.push_back('{0,0,0,0,1,0,0, 1,0,1,'h0002,0,'h8000,'hD,0}); // reset at cnt=2
    tbl.push_back('{1,0,0,0,0,0,0, 0,0,0,'h0000,0,'h0000,'h0,0});
    tbl.push_back('{1,1,2,1,0,0,0, 0,0,0,'h0000,0,'h0000,'h0,0});
    tbl.push_back('{1,0,0,0,1,0,0, 1,1,0,'h0000,0,'h0000,'h1,0});
    tbl.push_back('{1,0,0,0,1,0,0, 1,1,0,'h0001,0,'h0000,'h1,0});
    tbl.push_back('{1,0,0,0,0,0,0, 0,0,0,'h0000,0,'h0000,'h2,0});
    tbl.push_back('{1,0,0,0,0,1,0, 0,0,0,'h0000,0,'h0000,'h2,0});
    tbl.push_back('{1,1,1,0,0,0,0, 0,0,0,'h0000,1,'h0000,'h3,0});
    tbl.push_back('{1,0,0,0,1,0,1, 1,0,1,'h8000,0,'h0000,'h7,0}); // load end + done same cycle
    tbl.push_back('{1,0,0,0,0,0,0, 0,0,0,'h0000,0,'h0000,'h8,0});

    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].st, tbl[i].len, tbl[i].fc, tbl[i].vld, tbl[i].req, tbl[i].done);
      #1;
      check($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].wfc, tbl[i].wcnn, tbl[i].addr,
            tbl[i].gnt, tbl[i].ptr, tbl[i].bs, tbl[i].err);
    end

    // Random traffic against the model, starting from a fresh reset.
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      bit rst, st, fc, vld, req, done;
      int len;
      rst  = ($urandom_range(0, 299) != 0);
      st   = ($urandom_range(0, 5) == 0);
      len  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      fc   = $urandom_range(0, 1) == 1;
      vld  = ($urandom_range(0, 9) < 7);
      req  = $urandom_range(0, 1) == 1;
      done = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      drive(rst, st, len, fc, vld, req, done);
      #1;
      check($sformatf("rand%0d", c), m_lmode == 2, m_lmode == 2 && vld && m_fc == 1,
            m_lmode == 2 && vld && m_fc == 0, m_wb * 32768 + m_cnt, m_gnt == 1, m_ptr,
            m_bank[1] * 4 + m_bank[0], m_err == 1);
      model_step(rst, st, len, fc, vld, req, done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
